// File: rtl/key_expand_seq_pkg.sv
// Shared AES helpers for the key-expansion engine: legal key lengths,
// GF(2^8) doubling, the byte S-box and the RotWord byte rotation.
package key_expand_seq_pkg;

    typedef logic [31:0] word_t;

    localparam int NK_AES128 = 4;
    localparam int NK_AES192 = 6;
    localparam int NK_AES256 = 8;

    function automatic logic nk_is_legal(input int nk);
        return (nk == NK_AES128) || (nk == NK_AES192) || (nk == NK_AES256);
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic word_t rot_word(input word_t w);
        return {w[23:0], w[31:24]};
    endfunction

    // Entry 0 sits leftmost, so SBOX[b] is the substitution of byte b.
    localparam logic [0:255][7:0] SBOX = {
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[b];
    endfunction

endpackage

// File: rtl/key_expand_seq_sub_word.sv
// SubWord: the AES S-box applied to each byte of a 32-bit word.
module key_expand_seq_sub_word
    import key_expand_seq_pkg::*;
(
    input  logic [31:0] w_i,
    output logic [31:0] w_o
);

    assign w_o = {sbox(w_i[31:24]), sbox(w_i[23:16]), sbox(w_i[15:8]), sbox(w_i[7:0])};

endmodule

// File: rtl/key_expand_seq.sv
// Sequential AES key expansion: one schedule word per cycle, four words
// packed into a round key and handed out over a valid/ready handshake.
module key_expand_seq
    import key_expand_seq_pkg::*;
#(
    parameter int NK = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [255:0] key_in,
    output logic         busy,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic [3:0]   rk_index,
    output logic [127:0] rk_out,
    output logic         done,
    output logic [1:0]   state_dbg
);

    localparam int NR = NK + 6;
    localparam int NW = 4 * (NR + 1);
    localparam int WW = 32 * NK;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;

    if (!nk_is_legal(NK)) begin : g_bad_nk
        $error("key_expand_seq: NK must be 4, 6 or 8");
    end

    if (NK < 8) begin : g_key_hi
        logic unused_key_hi;
        assign unused_key_hi = ^key_in[255:WW];
    end

    // Handshake: a round key moves on any rising edge where rk_valid and
    // rk_ready are both high; rk_out/rk_index hold while rk_valid waits.
    logic [1:0]    state_q, state_d;
    logic [WW-1:0] win_q, win_d;
    logic [5:0]    i_q, i_d;
    logic [2:0]    ph_q, ph_d;
    logic [7:0]    rcon_q, rcon_d;
    logic [127:0]  asm_q, asm_d;
    logic          rk_valid_q, rk_valid_d;
    logic [3:0]    rk_index_q, rk_index_d;
    logic          done_q, done_d;

    word_t prev_w, oldest_w, sub_in, sub_out, t_w, new_w;
    logic  is_key_word, step, xfer;

    // The window keeps the last NK words with the oldest in the MSBs; while
    // the key words are emitted it simply rotates, ending in schedule order.
    assign prev_w      = win_q[31:0];
    assign oldest_w    = win_q[WW-1 -: 32];
    assign is_key_word = (i_q < 6'(NK));
    assign sub_in      = (ph_q == 3'd0) ? rot_word(prev_w) : prev_w;

    key_expand_seq_sub_word u_sub_word (
        .w_i (sub_in),
        .w_o (sub_out)
    );

    always_comb begin
        t_w = prev_w;
        if (ph_q == 3'd0) begin
            t_w = sub_out ^ {rcon_q, 24'h0};
        end else if ((NK == 8) && (ph_q == 3'd4)) begin
            t_w = sub_out;
        end
    end

    assign new_w = is_key_word ? oldest_w : (oldest_w ^ t_w);
    assign step  = (state_q == ST_RUN) && (!rk_valid_q || rk_ready);
    assign xfer  = rk_valid_q && rk_ready;

    always_comb begin
        state_d    = state_q;
        win_d      = win_q;
        i_d        = i_q;
        ph_d       = ph_q;
        rcon_d     = rcon_q;
        asm_d      = asm_q;
        rk_valid_d = rk_valid_q;
        rk_index_d = rk_index_q;
        done_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    win_d   = key_in[WW-1:0];
                    i_d     = 6'd0;
                    ph_d    = 3'd0;
                    rcon_d  = 8'h01;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (step) begin
                    win_d = {win_q[WW-33:0], new_w};
                    i_d   = i_q + 6'd1;
                    ph_d  = (ph_q == 3'(NK - 1)) ? 3'd0 : ph_q + 3'd1;
                    if (!is_key_word && (ph_q == 3'd0)) begin
                        rcon_d = xtime(rcon_q);
                    end
                    case (i_q[1:0])
                        2'd0:    asm_d[127:96] = new_w;
                        2'd1:    asm_d[95:64]  = new_w;
                        2'd2:    asm_d[63:32]  = new_w;
                        default: asm_d[31:0]   = new_w;
                    endcase
                    if (i_q == 6'(NW - 1)) begin
                        state_d = ST_FLUSH;
                    end
                end
            end
            ST_FLUSH: begin
                if (xfer) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A transfer and the completing word of the next key never coincide,
        // so clearing first and then setting is safe.
        if (xfer) begin
            rk_valid_d = 1'b0;
        end
        if (step && (i_q[1:0] == 2'd3)) begin
            rk_valid_d = 1'b1;
            rk_index_d = i_q[5:2];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            win_q      <= '0;
            i_q        <= '0;
            ph_q       <= '0;
            rcon_q     <= 8'h01;
            asm_q      <= '0;
            rk_valid_q <= 1'b0;
            rk_index_q <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            win_q      <= win_d;
            i_q        <= i_d;
            ph_q       <= ph_d;
            rcon_q     <= rcon_d;
            asm_q      <= asm_d;
            rk_valid_q <= rk_valid_d;
            rk_index_q <= rk_index_d;
            done_q     <= done_d;
        end
    end

    assign busy      = (state_q != ST_IDLE);
    assign rk_valid  = rk_valid_q;
    assign rk_index  = rk_index_q;
    assign rk_out    = asm_q;
    assign done      = done_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_key_expand_seq.sv
// Bench for key_expand_seq: one instance per key length, checked against
// FIPS-197 vectors and a word-array key-schedule model built from GF math.
module tb_key_expand_seq;

    logic         clk;
    logic         rst_n;
    logic [255:0] key_in;
    logic         start_v    [3];
    logic         rk_ready_v [3];
    logic         busy_v     [3];
    logic         rk_valid_v [3];
    logic         done_v     [3];
    logic [3:0]   rk_index_v [3];
    logic [127:0] rk_out_v   [3];
    logic [1:0]   state_v    [3];

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]   tb_sbox [256];
    logic [7:0]   rcon_tab [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
    logic [31:0]  m_w [60];
    logic [127:0] m_rk [15];
    logic [127:0] got_rk [15];
    logic [127:0] exp_q [$];

    localparam logic [255:0] KEY128 = 256'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [255:0] KEY192 = 256'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
    localparam logic [255:0] KEY256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    typedef struct {
        int           d;
        logic [255:0] key;
        int           round;
        logic [127:0] exp;
    } vec_t;
    vec_t vecs [7];

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    key_expand_seq #(.NK(4)) u_k4 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .key_in(key_in),
        .busy(busy_v[0]), .rk_valid(rk_valid_v[0]), .rk_ready(rk_ready_v[0]),
        .rk_index(rk_index_v[0]), .rk_out(rk_out_v[0]), .done(done_v[0]), .state_dbg(state_v[0])
    );
    key_expand_seq #(.NK(6)) u_k6 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .key_in(key_in),
        .busy(busy_v[1]), .rk_valid(rk_valid_v[1]), .rk_ready(rk_ready_v[1]),
        .rk_index(rk_index_v[1]), .rk_out(rk_out_v[1]), .done(done_v[1]), .state_dbg(state_v[1])
    );
    key_expand_seq #(.NK(8)) u_k8 (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]), .key_in(key_in),
        .busy(busy_v[2]), .rk_valid(rk_valid_v[2]), .rk_ready(rk_ready_v[2]),
        .rk_index(rk_index_v[2]), .rk_out(rk_out_v[2]), .done(done_v[2]), .state_dbg(state_v[2])
    );

    // ---------------- checking helpers ----------------
    task automatic check_eq(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int nk_of(input int d);
        return (d == 0) ? 4 : ((d == 1) ? 6 : 8);
    endfunction

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b);
        logic [7:0] a = a_in;
        logic [7:0] p = 8'h00;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rl8(input logic [7:0] b, input int n);
        return 8'((b << n) | (b >> (8 - n)));
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            tb_sbox[x] = inv ^ rl8(inv, 1) ^ rl8(inv, 2) ^ rl8(inv, 3) ^ rl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] m_sub(input logic [31:0] x);
        return {tb_sbox[x[31:24]], tb_sbox[x[23:16]], tb_sbox[x[15:8]], tb_sbox[x[7:0]]};
    endfunction

    task automatic model_expand(input int nk, input logic [255:0] key);
        logic [31:0] temp;
        int nw = 4 * (nk + 7);
        for (int i = 0; i < nw; i++) begin
            if (i < nk) begin
                m_w[i] = 32'(key >> (32 * (nk - 1 - i)));
            end else begin
                temp = m_w[i-1];
                if (i % nk == 0)
                    temp = m_sub({temp[23:0], temp[31:24]}) ^ {rcon_tab[i/nk - 1], 24'h0};
                else if (nk > 6 && i % nk == 4)
                    temp = m_sub(temp);
                m_w[i] = m_w[i-nk] ^ temp;
            end
        end
        exp_q.delete();
        for (int r = 0; r <= nk + 6; r++) begin
            m_rk[r] = {m_w[4*r], m_w[4*r+1], m_w[4*r+2], m_w[4*r+3]};
            exp_q.push_back(m_rk[r]);
        end
    endtask

    // ---------------- driver + scoreboard ----------------
    task automatic check_idle_outputs(input int d, input string tag);
        check_eq({tag, "_busy"},     128'(busy_v[d]),     128'd0);
        check_eq({tag, "_rk_valid"}, 128'(rk_valid_v[d]), 128'd0);
        check_eq({tag, "_rk_index"}, 128'(rk_index_v[d]), 128'd0);
        check_eq({tag, "_rk_out"},   rk_out_v[d],         128'd0);
        check_eq({tag, "_done"},     128'(done_v[d]),     128'd0);
    endtask

    task automatic run_dut(input int d, input logic [255:0] key, input int pct, input bit stray_start);
        int nr = nk_of(d) + 6;
        int rnd = 0;
        int cyc = 0;
        bit hold = 0;
        bit expect_done = 0;
        bit finished = 0;
        bit r;
        logic [127:0] held_out, exp_rk;
        logic [3:0]   held_idx;

        model_expand(nk_of(d), key);
        @(negedge clk);
        check_eq("idle_before_start", 128'(busy_v[d]), 128'd0);
        key_in        = key;
        start_v[d]    = 1'b1;
        rk_ready_v[d] = 1'b0;
        @(negedge clk);
        start_v[d] = 1'b0;
        key_in     = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        check_eq("busy_after_start", 128'(busy_v[d]), 128'd1);

        while (!finished && cyc < 3000) begin
            if (stray_start && cyc == 6) begin
                start_v[d] = 1'b1;
                key_in     = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            end else begin
                start_v[d] = 1'b0;
            end

            if (expect_done) begin
                check_eq("done_pulse", 128'(done_v[d]), 128'd1);
                check_eq("done_valid_excl", 128'(rk_valid_v[d]), 128'd0);
                check_eq("busy_after_done", 128'(busy_v[d]), 128'd0);
                if (pct == 100) check_eq("done_cycle", 128'(cyc), 128'(4 * (nr + 1) + 1));
                finished = 1;
            end else begin
                check_eq("done_early", 128'(done_v[d]), 128'd0);
                if (hold) begin
                    check_eq("valid_held", 128'(rk_valid_v[d]), 128'd1);
                    check_eq("rk_out_stable", rk_out_v[d], held_out);
                    check_eq("rk_index_stable", 128'(rk_index_v[d]), 128'(held_idx));
                end
                if (rk_valid_v[d]) begin
                    if (pct == 100) check_eq("key_cycle", 128'(cyc), 128'(4 * (rnd + 1)));
                    r = ($urandom_range(100, 1) <= pct);
                    rk_ready_v[d] = r;
                    if (r) begin
                        if (exp_q.size() == 0) begin
                            check_eq("extra_key", 128'd1, 128'd0);
                        end else begin
                            exp_rk = exp_q.pop_front();
                            check_eq("rk_out", rk_out_v[d], exp_rk);
                            check_eq("rk_index", 128'(rk_index_v[d]), 128'(rnd));
                            if (rnd < 15) got_rk[rnd] = rk_out_v[d];
                        end
                        rnd++;
                        hold = 0;
                        if (rnd == nr + 1) expect_done = 1;
                    end else begin
                        hold     = 1;
                        held_out = rk_out_v[d];
                        held_idx = rk_index_v[d];
                    end
                end else begin
                    rk_ready_v[d] = ($urandom_range(100, 1) <= pct);
                end
            end
            if (!finished) begin
                @(negedge clk);
                cyc++;
            end
        end
        if (!finished) check_eq("expansion_timeout", 128'(cyc), 128'd0);
        start_v[d]    = 1'b0;
        rk_ready_v[d] = 1'b0;
        @(negedge clk);
        check_eq("done_one_cycle", 128'(done_v[d]), 128'd0);
    endtask

    task automatic reset_abort();
        int  cyc = 0;
        bit  found = 0;
        @(negedge clk);
        key_in        = KEY128;
        start_v[0]    = 1'b1;
        rk_ready_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        while (!found && cyc < 200) begin
            if (rk_valid_v[0] && rk_index_v[0] == 4'd5) found = 1;
            else begin
                @(negedge clk);
                cyc++;
            end
        end
        check_eq("reach_round5", 128'(found), 128'd1);
        #1 rst_n = 1'b0;
        #1 check_idle_outputs(0, "async_reset");
        @(negedge clk);
        rst_n         = 1'b1;
        rk_ready_v[0] = 1'b0;
        repeat (6) @(negedge clk);
        check_eq("no_restart_busy", 128'(busy_v[0]), 128'd0);
        check_eq("no_restart_valid", 128'(rk_valid_v[0]), 128'd0);
        run_dut(0, KEY128, 100, 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [255:0] rkey;
        rst_n  = 1'b0;
        key_in = '0;
        for (int d = 0; d < 3; d++) begin
            start_v[d]    = 1'b0;
            rk_ready_v[d] = 1'b0;
        end
        build_sbox();

        vecs[0] = '{0, KEY128, 0,  128'h2b7e151628aed2a6abf7158809cf4f3c};
        vecs[1] = '{0, KEY128, 1,  128'ha0fafe1788542cb123a339392a6c7605};
        vecs[2] = '{0, KEY128, 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
        vecs[3] = '{1, KEY192, 12, 128'he98ba06f448c773c8ecc720401002202};
        vecs[4] = '{2, KEY256, 0,  128'h603deb1015ca71be2b73aef0857d7781};
        vecs[5] = '{2, KEY256, 1,  128'h1f352c073b6108d72d9810a30914dff4};
        vecs[6] = '{2, KEY256, 14, 128'hfe4890d1e6188d0b046df344706c631e};

        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++) check_idle_outputs(d, "reset");
        rst_n = 1'b1;
        @(negedge clk);
        for (int d = 0; d < 3; d++) check_idle_outputs(d, "post_reset");

        for (int k = 0; k < 7; k++) begin
            model_expand(nk_of(vecs[k].d), vecs[k].key);
            check_eq("model_vector", m_rk[vecs[k].round], vecs[k].exp);
            run_dut(vecs[k].d, vecs[k].key, 100, 0);
            check_eq("dut_vector", got_rk[vecs[k].round], vecs[k].exp);
        end

        run_dut(0, KEY128, 30, 0);
        run_dut(0, KEY128, 100, 1);
        check_eq("stray_start_last", got_rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        reset_abort();

        for (int n = 0; n < 6; n++) begin
            rkey = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            run_dut(n % 3, rkey, int'($urandom_range(100, 20)), n == 4);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        n_fail++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule
